irig_frame_decoder: RTL and testbench

Parametrised IRIG-B (B00x) frame decoder, successor to the BCD-only decoder in the irig_gps subsystem. Classifies debounced pulse widths into 0/1/P symbols and tracks the full 100-symbol frame. Checks every position marker and validates the BCD digits. Outputs binary sec/min/hr/day/year, a lock flag, error pulses and an on-time PPS aligned to the rising edge of the Pr reference marker. It sits between the IO synchroniser of the IRIG input pin and the timestamp/PPS logic.

---
 rtl/irig_frame_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_irig_frame_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irig_frame_decoder.sv
// IRIG-B (B00x) decoder: pulse-width symbol classifier, 100-symbol frame tracker and BCD time decode.
// Optional macro IRIG_SBS_EN enables decode and range check of the straight-binary-seconds field.
`timescale 1ns/1ps
module irig_frame_decoder #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic [CNT_W-1:0] debounce,
  input  logic [CNT_W-1:0] min_width,
  input  logic [CNT_W-1:0] zero_max,
  input  logic [CNT_W-1:0] one_max,
  input  logic [CNT_W-1:0] pid_max,
  input  logic [CNT_W-1:0] timeout,
  output logic [5:0]       sec,
  output logic [5:0]       min,
  output logic [4:0]       hr,
  output logic [8:0]       day,
  output logic [6:0]       year,
  output logic [16:0]      sbs,
  output logic             time_valid,
  output logic             locked,
  output logic             frame_err,
  output logic             pps,
  output logic             sym_valid,
  output logic [1:0]       sym
);
  localparam logic [1:0] SYM_ZERO = 2'd0;
  localparam logic [1:0] SYM_ONE  = 2'd1;
  localparam logic [1:0] SYM_P    = 2'd2;
  localparam logic [1:0] SYM_ERR  = 2'd3;

  typedef enum logic {HUNT, CAPTURE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s, deb, deb_q, rise, fall;
  logic [CNT_W-1:0]       deb_cnt, width, edge_cnt;
  logic [1:0]             cls;
  state_t                 state;
  logic [6:0]             idx;
  logic                   p_seen, chk;
  logic [99:0]            frame;

  assign din_s = sync_q[SYNC_STAGES-1];
  assign rise  = deb & ~deb_q;
  assign fall  = ~deb & deb_q;

  // Width thresholds applied at the debounced falling edge
  always_comb begin
    cls = SYM_ERR;
    if (width < min_width)     cls = SYM_ERR;
    else if (width < zero_max) cls = SYM_ZERO;
    else if (width < one_max)  cls = SYM_ONE;
    else if (width < pid_max)  cls = SYM_P;
  end

  // Synchroniser, debounce, width / inter-edge counters and symbol output
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      sync_q    <= '0;
      deb       <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt   <= '0;
      width     <= '0;
      edge_cnt  <= '0;
      sym_valid <= 1'b0;
      sym       <= SYM_ZERO;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      deb_q  <= deb;
      if (din_s == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt + CNT_W'(1) >= debounce) begin
        deb     <= din_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
      if (rise)                        width <= '0;
      else if (deb && (width != '1))   width <= width + CNT_W'(1);
      if (rise)                        edge_cnt <= '0;
      else if (edge_cnt != '1)         edge_cnt <= edge_cnt + CNT_W'(1);
      sym_valid <= fall;
      if (fall) sym <= cls;
    end
  end

  // BCD fields of the captured frame
  logic [3:0] s_u, m_u, h_u, d_u, d_t, y_u, y_t;
  logic [2:0] s_t, m_t;
  logic [1:0] h_t, d_h;
  logic [6:0] sec_b, min_b;
  logic [5:0] hr_b;
  logic [9:0] day_b;
  logic [7:0] year_b;
  logic       sbs_ok, bcd_ok, unused_bits;

  assign s_u = frame[4:1];   assign s_t = frame[8:6];
  assign m_u = frame[13:10]; assign m_t = frame[17:15];
  assign h_u = frame[23:20]; assign h_t = frame[26:25];
  assign d_u = frame[33:30]; assign d_t = frame[38:35]; assign d_h = frame[41:40];
  assign y_u = frame[53:50]; assign y_t = frame[58:55];

  assign sec_b  = 7'(s_t) * 7'd10 + 7'(s_u);
  assign min_b  = 7'(m_t) * 7'd10 + 7'(m_u);
  assign hr_b   = 6'(h_t) * 6'd10 + 6'(h_u);
  assign day_b  = 10'(d_h) * 10'd100 + 10'(d_t) * 10'd10 + 10'(d_u);
  assign year_b = 8'(y_t) * 8'd10 + 8'(y_u);

  // Marker slots and the SBS region are not part of the BCD decode
  assign unused_bits = ^{frame[0], frame[5], frame[9], frame[14], frame[19:18], frame[24],
                         frame[29:27], frame[34], frame[39], frame[49:42], frame[54], frame[99:59]};

`ifdef IRIG_SBS_EN
  logic [16:0] sbs_b;
  assign sbs_b  = {frame[97:90], frame[88:80]};
  assign sbs_ok = (sbs_b <= 17'd86399);
`else
  assign sbs_ok = 1'b1;
  assign sbs    = '0;
`endif

  assign bcd_ok = (s_u <= 4'd9) && (m_u <= 4'd9) && (h_u <= 4'd9) && (d_u <= 4'd9) &&
                  (d_t <= 4'd9) && (y_u <= 4'd9) && (y_t <= 4'd9) &&
                  (sec_b <= 7'd59) && (min_b <= 7'd59) && (hr_b <= 6'd23) &&
                  (day_b >= 10'd1) && (day_b <= 10'd366) && sbs_ok;

  function automatic logic is_marker(input logic [6:0] i);
    case (i)
      7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
      7'd59, 7'd69, 7'd79, 7'd89, 7'd99: is_marker = 1'b1;
      default:                           is_marker = 1'b0;
    endcase
  endfunction

  // Frame tracking FSM with registered time outputs
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state <= HUNT;
      idx <= '0; p_seen <= 1'b0; chk <= 1'b0; frame <= '0;
      sec <= '0; min <= '0; hr <= '0; day <= '0; year <= '0;
      time_valid <= 1'b0; locked <= 1'b0; frame_err <= 1'b0; pps <= 1'b0;
`ifdef IRIG_SBS_EN
      sbs <= '0;
`endif
    end else begin
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      pps        <= 1'b0;
      chk        <= 1'b0;
      if (rise && (state == CAPTURE) && (idx == 7'd0) && locked) pps <= 1'b1;
      if (chk) begin
        if (bcd_ok) begin
          sec <= sec_b[5:0]; min <= min_b[5:0]; hr <= hr_b[4:0];
          day <= day_b[8:0]; year <= year_b[6:0];
`ifdef IRIG_SBS_EN
          sbs <= sbs_b;
`endif
          time_valid <= 1'b1;
          locked     <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          locked    <= 1'b0;
        end
      end
      if (sym_valid) begin
        if (state == HUNT) begin
          if (sym == SYM_P && p_seen) begin
            state  <= CAPTURE;
            idx    <= 7'd1;
            p_seen <= 1'b0;
          end else begin
            p_seen <= (sym == SYM_P);
          end
        end else if ((sym == SYM_ERR) || ((sym == SYM_P) != is_marker(idx))) begin
          frame_err <= 1'b1;
          state     <= HUNT;
          locked    <= 1'b0;
          p_seen    <= (sym == SYM_P);
        end else begin
          frame[idx] <= (sym == SYM_ONE);
          if (idx == 7'd99) begin
            idx <= '0;
            chk <= 1'b1;
          end else begin
            idx <= idx + 7'd1;
          end
        end
      end else if ((state == CAPTURE) && (edge_cnt >= timeout)) begin
        frame_err <= 1'b1;
        state     <= HUNT;
        locked    <= 1'b0;
        p_seen    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_irig_frame_decoder.sv
// Directed bench for irig_frame_decoder using time-scaled IRIG-B frames (60-cycle symbols).
`timescale 1ns/1ps
module tb_irig_frame_decoder;
  localparam int PERIOD = 60;
  localparam int W0 = 12;
  localparam int W1 = 30;
  localparam int WP = 48;
`ifdef IRIG_SBS_EN
  localparam bit SBS_ON = 1'b1;
`else
  localparam bit SBS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, din;
  logic [23:0] debounce, min_width, zero_max, one_max, pid_max, timeout;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic [8:0] day;
  logic [6:0] year;
  logic [16:0] sbs;
  logic time_valid, locked, frame_err, pps, sym_valid;
  logic [1:0] sym;

  int n_checks = 0;
  int n_err = 0;
  int tv_cnt = 0;
  int fe_cnt = 0;
  int pps_cnt = 0;
  logic [99:0] fa, fbad, fb, fc;

  always #5 clk = ~clk;

  irig_frame_decoder dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .debounce(debounce), .min_width(min_width), .zero_max(zero_max),
    .one_max(one_max), .pid_max(pid_max), .timeout(timeout),
    .sec(sec), .min(min), .hr(hr), .day(day), .year(year), .sbs(sbs),
    .time_valid(time_valid), .locked(locked), .frame_err(frame_err),
    .pps(pps), .sym_valid(sym_valid), .sym(sym)
  );

  // Pulse counters sampled on the inactive edge
  always @(negedge clk) begin
    if (time_valid) tv_cnt++;
    if (frame_err)  fe_cnt++;
    if (pps)        pps_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [99:0] put(input logic [99:0] f, input int pos, input int n, input int val);
    logic [99:0] r;
    r = f;
    for (int k = 0; k < n; k++) r[pos+k] = val[k];
    return r;
  endfunction

  function automatic logic [99:0] mk_frame(input int s, input int m, input int h,
                                            input int d, input int y, input bit bad);
    logic [99:0] f;
    int sb;
    f  = '0;
    sb = h * 3600 + m * 60 + s;
    f = put(f, 1, 4, bad ? 10 : s % 10);
    f = put(f, 6, 3, s / 10);
    f = put(f, 10, 4, m % 10);
    f = put(f, 15, 3, m / 10);
    f = put(f, 20, 4, h % 10);
    f = put(f, 25, 2, h / 10);
    f = put(f, 30, 4, d % 10);
    f = put(f, 35, 4, (d / 10) % 10);
    f = put(f, 40, 2, d / 100);
    f = put(f, 50, 4, y % 10);
    f = put(f, 55, 4, y / 10);
    f = put(f, 80, 9, sb);
    f = put(f, 90, 8, sb >> 9);
    return f;
  endfunction

  function automatic bit is_mk(input int i);
    return (i == 0) || (i % 10 == 9);
  endfunction

  // One symbol: high for w cycles (optional 2-cycle low glitch), low for the rest of the period
  task automatic send_sym(input int w, input bit glitch);
    din = 1'b1;
    if (glitch) begin
      repeat (4) @(negedge clk);
      din = 1'b0;
      repeat (2) @(negedge clk);
      din = 1'b1;
      repeat (w - 6) @(negedge clk);
    end else begin
      repeat (w) @(negedge clk);
    end
    din = 1'b0;
    repeat (PERIOD - w) @(negedge clk);
  endtask

  task automatic send_frame(input logic [99:0] f, input int nsym, input int glitch_idx, input int zero_idx);
    for (int i = 0; i < nsym; i++) begin
      if (is_mk(i) && i != zero_idx)     send_sym(WP, 1'b0);
      else if (f[i] && i != zero_idx)    send_sym(W1, 1'b0);
      else                               send_sym(W0, i == glitch_idx);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_time(input string tag, input int s, input int m, input int h,
                          input int d, input int y, input int sb);
    chk({tag, ".sec"},  int'(sec),  s);
    chk({tag, ".min"},  int'(min),  m);
    chk({tag, ".hr"},   int'(hr),   h);
    chk({tag, ".day"},  int'(day),  d);
    chk({tag, ".year"}, int'(year), y);
    chk({tag, ".sbs"},  int'(sbs),  SBS_ON ? sb : 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din = 1'b0;
    debounce = 24'd3; min_width = 24'd6; zero_max = 24'd21;
    one_max = 24'd39; pid_max = 24'd57; timeout = 24'd90;
    fa   = mk_frame(56, 34, 12, 123, 24, 1'b0);
    fbad = mk_frame(56, 34, 12, 123, 24, 1'b1);
    fb   = mk_frame(59, 59, 23, 366, 99, 1'b0);
    fc   = mk_frame(0, 0, 0, 1, 0, 1'b0);

    // Reset state
    repeat (5) @(negedge clk);
    settle();
    chk_time("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.locked", int'(locked), 0);
    chk("reset.time_valid", int'(time_valid), 0);
    chk("reset.frame_err", int'(frame_err), 0);
    chk("reset.pps", int'(pps), 0);
    chk("reset.sym_valid", int'(sym_valid), 0);

    @(negedge clk) rst = 1'b0;
    // Frame 1: acquisition only
    send_frame(fa, 100, -1, -1);
    settle();
    chk("f1.tv_cnt", tv_cnt, 0);
    chk("f1.locked", int'(locked), 0);
    chk("f1.fe_cnt", fe_cnt, 0);

    // Frame 2: first decode
    @(negedge clk);
    send_frame(fa, 100, -1, -1);
    settle();
    chk("f2.tv_cnt", tv_cnt, 1);
    chk_time("f2", 56, 34, 12, 123, 24, 45296);
    chk("f2.locked", int'(locked), 1);
    chk("f2.pps_cnt", pps_cnt, 0);

    // Frame 3: first pps on Pr
    @(negedge clk);
    send_frame(fa, 100, -1, -1);
    settle();
    chk("f3.pps_cnt", pps_cnt, 1);
    chk("f3.tv_cnt", tv_cnt, 2);

    // Frame 4: 2-cycle glitch inside ZERO at index 5
    @(negedge clk);
    send_frame(fa, 100, 5, -1);
    settle();
    chk("f4.fe_cnt", fe_cnt, 0);
    chk("f4.tv_cnt", tv_cnt, 3);
    chk_time("f4", 56, 34, 12, 123, 24, 45296);
    chk("f4.pps_cnt", pps_cnt, 2);

    // Frame 5: index 29 sent as ZERO
    @(negedge clk);
    send_frame(fa, 100, -1, 29);
    settle();
    chk("f5.fe_cnt", fe_cnt, 1);
    chk("f5.locked", int'(locked), 0);
    chk("f5.pps_cnt", pps_cnt, 3);
    chk("f5.tv_cnt", tv_cnt, 3);

    // Frame 6: relock, no pps at its Pr
    @(negedge clk);
    send_frame(fa, 100, -1, -1);
    settle();
    chk("f6.pps_cnt", pps_cnt, 3);
    chk("f6.tv_cnt", tv_cnt, 4);
    chk("f6.locked", int'(locked), 1);

    // Frame 7: units seconds = 1010
    @(negedge clk);
    send_frame(fbad, 100, -1, -1);
    settle();
    chk("f7.fe_cnt", fe_cnt, 2);
    chk("f7.tv_cnt", tv_cnt, 4);
    chk("f7.locked", int'(locked), 0);
    chk("f7.pps_cnt", pps_cnt, 4);
    chk_time("f7hold", 56, 34, 12, 123, 24, 45296);

    // Frame 8: upper bounds 23:59:59 day 366 year 99
    @(negedge clk);
    send_frame(fb, 100, -1, -1);
    settle();
    chk("f8.tv_cnt", tv_cnt, 5);
    chk_time("f8", 59, 59, 23, 366, 99, 86399);
    chk("f8.locked", int'(locked), 1);
    chk("f8.pps_cnt", pps_cnt, 4);

    // Frame 9: lower bounds 00:00:00 day 1 year 0
    @(negedge clk);
    send_frame(fc, 100, -1, -1);
    settle();
    chk("f9.tv_cnt", tv_cnt, 6);
    chk_time("f9", 0, 0, 0, 1, 0, 0);
    chk("f9.pps_cnt", pps_cnt, 5);
    chk("f9.fe_cnt", fe_cnt, 2);

    // Frame 10: partial, then reset mid-frame
    @(negedge clk);
    send_frame(fa, 30, -1, -1);
    rst = 1'b1;
    settle();
    chk("f10.pps_cnt", pps_cnt, 6);
    chk_time("rst_mid", 0, 0, 0, 0, 0, 0);
    chk("rst_mid.locked", int'(locked), 0);
    @(negedge clk) rst = 1'b0;

    // Acquire again, enter CAPTURE, then hold din low past the timeout
    send_frame(fa, 100, -1, -1);
    send_frame(fa, 5, -1, -1);
    repeat (150) @(negedge clk);
    settle();
    chk("timeout.fe_cnt", fe_cnt, 3);
    chk("timeout.locked", int'(locked), 0);
    chk("timeout.tv_cnt", tv_cnt, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
